// File: rtl/mult4x4_pkg.sv
// rtl/mult4x4_pkg.sv - shared states, mux/shift encodings and 2x2 product helper for the 4x4 multiplier
package mult4x4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PP_HH = 3'd1,
        PP_HL = 3'd2,
        PP_LH = 3'd3,
        PP_LL = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] SHIFT_4 = 2'd0;
    localparam logic [1:0] SHIFT_2 = 2'd1;
    localparam logic [1:0] SHIFT_0 = 2'd2;

    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    // The shared 2x2 multiplier: largest product is 3*3 = 9, so 4 bits suffice.
    function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
        return {2'b00, x} * {2'b00, y};
    endfunction

endpackage

// File: rtl/multiplier4x4_datapath.sv
// rtl/multiplier4x4_datapath.sv - operand registers, slice muxes, shared 2x2 multiplier and accumulator
module multiplier4x4_datapath
    import mult4x4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ldA,
    input  logic       ldB,
    input  logic       selA,
    input  logic       selB,
    input  logic [1:0] shiftSel,
    input  logic       ldRes,
    input  logic       init0Res,
    output logic [7:0] res
);

    logic [3:0] a_q, b_q;
    logic [7:0] res_q, res_d;
    logic [1:0] slice_a, slice_b;
    logic [3:0] pp;
    logic [7:0] pp_shifted;

    always_comb begin
        slice_a = (selA == SEL_HI) ? a_q[3:2] : a_q[1:0];
        slice_b = (selB == SEL_HI) ? b_q[3:2] : b_q[1:0];
        pp      = mul2x2(slice_a, slice_b);
        case (shiftSel)
            SHIFT_4: pp_shifted = {pp, 4'b0000};
            SHIFT_2: pp_shifted = {2'b00, pp, 2'b00};
            default: pp_shifted = {4'b0000, pp};
        endcase
        // Clear wins over accumulate; the sum peaks at 0xE1 so no carry out is lost.
        if (init0Res) begin
            res_d = 8'h00;
        end else if (ldRes) begin
            res_d = res_q + pp_shifted;
        end else begin
            res_d = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= 4'h0;
            b_q   <= 4'h0;
            res_q <= 8'h00;
        end else begin
            if (ldA) a_q <= a;
            if (ldB) b_q <= b;
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/multiplier4x4_top.sv
// rtl/multiplier4x4_top.sv - 4x4 unsigned multiplier: controller plus datapath
module multiplier4x4_top
    import mult4x4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] res
);

    logic       ldA, ldB, selA, selB, ldRes, init0Res;
    logic [1:0] shiftSel;

    multiplier4x4_controller u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .ldA      (ldA),
        .ldB      (ldB),
        .selA     (selA),
        .selB     (selB),
        .shiftSel (shiftSel),
        .ldRes    (ldRes),
        .init0Res (init0Res)
    );

    multiplier4x4_datapath u_dp (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .ldA      (ldA),
        .ldB      (ldB),
        .selA     (selA),
        .selB     (selB),
        .shiftSel (shiftSel),
        .ldRes    (ldRes),
        .init0Res (init0Res),
        .res      (res)
    );

endmodule

// File: rtl/multiplier4x4_controller.sv
// rtl/multiplier4x4_controller.sv - sequencer stepping four 2-bit partial products through the datapath
module multiplier4x4_controller
    import mult4x4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       ldA,
    output logic       ldB,
    output logic       selA,
    output logic       selB,
    output logic [1:0] shiftSel,
    output logic       ldRes,
    output logic       init0Res
);

    state_t state_q, state_d;
    logic   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control is decoded from state alone; only the load/clear strobes also look at start.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        selA     = SEL_HI;
        selB     = SEL_HI;
        shiftSel = SHIFT_4;
        ldRes    = 1'b0;
        ready    = (state_q == IDLE) || (state_q == DONE);
        accept   = start & ready;

        case (state_q)
            IDLE: begin
                if (accept) state_d = PP_HH;
            end
            PP_HH: begin
                busy     = 1'b1;
                ldRes    = 1'b1;
                selA     = SEL_HI;
                selB     = SEL_HI;
                shiftSel = SHIFT_4;
                state_d  = abort ? IDLE : PP_HL;
            end
            PP_HL: begin
                busy     = 1'b1;
                ldRes    = 1'b1;
                selA     = SEL_HI;
                selB     = SEL_LO;
                shiftSel = SHIFT_2;
                state_d  = abort ? IDLE : PP_LH;
            end
            PP_LH: begin
                busy     = 1'b1;
                ldRes    = 1'b1;
                selA     = SEL_LO;
                selB     = SEL_HI;
                shiftSel = SHIFT_2;
                state_d  = abort ? IDLE : PP_LL;
            end
            PP_LL: begin
                busy     = 1'b1;
                ldRes    = 1'b1;
                selA     = SEL_LO;
                selB     = SEL_LO;
                shiftSel = SHIFT_0;
                state_d  = abort ? IDLE : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = accept ? PP_HH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ldA      = accept;
        ldB      = accept;
        init0Res = accept;
    end

endmodule

// File: doc/multiplier4x4_controller.md
# multiplier4x4_controller

Sequencer for the 4x4 unsigned multiplier datapath built around the shared 2x2 multiplier. It accepts an operand pair through a start/ready handshake, captures the operands into the datapath registers, and steps the four 2-bit partial products through the shift mux and accumulator. It then signals completion with a one-cycle done pulse. It sits beside the datapath inside the 4x4 multiplier top level, and is the block the complex-multiplier control drives.

## Interface
- No parameters; widths are fixed by the datapath.
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request: operands on datapath A/B are valid this cycle
- abort  in  1  synchronous cancel of an operation in progress
- ready  out  1  controller can accept start this cycle
- busy  out  1  partial-product accumulation in progress
- done  out  1  one-cycle pulse: datapath res holds the final product
- ldA  out  1  load operand register A
- ldB  out  1  load operand register B
- selA  out  1  0 = A[3:2], 1 = A[1:0]
- selB  out  1  0 = B[3:2], 1 = B[1:0]
- shiftSel  out  2  0 = <<4, 1 = <<2, 2 = <<0; 3 is never driven
- ldRes  out  1  accumulate into result register
- init0Res  out  1  clear result register

## Operation
- States: IDLE, PP_HH, PP_HL, PP_LH, PP_LL, DONE.
- Accept condition: start & ready.
  - ready = 1 in IDLE and DONE, 0 otherwise.
- On accept, ldA = ldB = init0Res = 1 in the same cycle; these three are Mealy outputs and are 0 in all other cycles.
  - The next state is PP_HH.
  - Operands are sampled only on the accept edge, so the requester need not hold A/B afterwards.
- Accumulation states (Moore decode, ldRes = 1, busy = 1):
  - PP_HH: selA = 0, selB = 0, shiftSel = 0
  - PP_HL: selA = 0, selB = 1, shiftSel = 1
  - PP_LH: selA = 1, selB = 0, shiftSel = 1
  - PP_LL: selA = 1, selB = 1, shiftSel = 2
- Transitions: PP_HH → PP_HL → PP_LH → PP_LL → DONE, unconditional, one cycle each.
- DONE: done = 1 for exactly one cycle.
  - Next state is PP_HH if a start is accepted in that cycle (back-to-back), else IDLE.
- In IDLE and DONE: ldRes = 0, busy = 0; selA, selB and shiftSel are 0.
- Abort:
  - If abort = 1 in any PP_* state, the next state is IDLE; done is never pulsed for that operation.
  - ldRes stays asserted in the aborting cycle, so res holds a partial sum; it is cleared on the next accept.
  - Abort is ignored in IDLE and DONE. Start is ignored while busy.
- If start and abort are high in the same cycle: in IDLE/DONE the start wins; in PP_* the abort wins.
- Width rules: every partial product is at most 9 (4 bits). The maximum sum is 0xE1, so the 8-bit accumulator never overflows; the controller does no overflow handling.
- Reset (asynchronous, any state including mid-operation): state = IDLE.
  - Outputs after reset: ready = 1; all other outputs 0 (busy, done, ldA, ldB, selA, selB, shiftSel, ldRes, init0Res).

## Timing
- Start accepted in cycle 0 → PP_HH in cycle 1 … PP_LL in cycle 4 → done = 1 in cycle 5.
- Result timing:
  - res is 0 from the accept edge.
  - Final res is valid from cycle 5 and is held until the next accept edge.
- Throughput: one product per 5 cycles when start is held high through DONE.
- Latency is fixed; it does not depend on the data (no zero-skip).
- State register only; all datapath control is decoded combinationally from state, plus start for the Mealy signals.

## Structure
- Shared package mult4x4_pkg:
  - state enum (IDLE, PP_HH, PP_HL, PP_LH, PP_LL, DONE)
  - SHIFT_4 = 2'd0, SHIFT_2 = 2'd1, SHIFT_0 = 2'd2
  - SEL_HI = 1'b0, SEL_LO = 1'b1
- The datapath top level imports the same constants.
- Single module, no sub-module.
- Integration wrapper multiplier4x4_top (controller + datapath) is delivered alongside for verification.

## Test plan
- Reset mid-operation: assert rst during PP_LH → state IDLE immediately; ready = 1, all other outputs 0; the next start completes normally.
- A = 9, B = 6, single start (wrapper) → res after each accumulate 0x20, 0x30, 0x34, 0x36; done in cycle 5; selA/selB/shiftSel sequence matches the table above.
- A = 0xF, B = 0xF → res = 0xE1 at done; A = 0, B = 0xF → res = 0x00 and done still in cycle 5.
- Back-to-back: start held high, operand pairs (3,5) then (0xC,0xA) → done pulses 5 cycles apart; res = 0x0F then 0x78; init0Res asserted in each DONE accept cycle.
- Abort in PP_HL → no done; ready = 1 next cycle; a following start with A = 2, B = 7 gives res = 0x0E.
- Start while busy (cycles 1–4) → ignored: no ldA/ldB pulse, no change in sequence; start + abort together in IDLE → accepted.
